pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and memory-request stage upstream of Control_unit. Owns the PC,
//  drives imemaddr/imemREN, and sequences the data-memory access of LW/SW. Retires
//  each instruction on ihit, or on dhit for memory instructions, and latches halt.
//  Consumes PCsel/PC4EN/halt/cu_dmemREN/cu_dmemWEN, which Control_unit decodes
//  from imemload.
// PARAMETERS
//  PC_INIT   32'h0000_0000  PC value loaded on reset
// PORTS
//  CLK         in   1   clock; all state on rising edge
//  nRST        in   1   reset, asynchronous, active-low
//  ihit        in   1   instruction memory returned imemload for imemaddr
//  dhit        in   1   data memory completed current dmemREN/dmemWEN request
//  imemload    in   32  fetched instruction; must be held stable while imemaddr is unchanged
//  PCsel       in   2   control_sel_pkg PC select: PC_NP, PC_JR, PC_JI, PC_BR
//  PC4EN       in   1   1 = next PC is pc+4, overrides PCsel
//  halt        in   1   decoded HALT
//  cu_dmemREN  in   1   decoded load
//  cu_dmemWEN  in   1   decoded store
//  rdat1       in   32  GPR[rs]; JR target
//  imemaddr    out  32  current PC
//  imemREN     out  1   instruction read request
//  dmemREN     out  1   data read request, registered
//  dmemWEN     out  1   data write request, registered
//  pc4         out  32  imemaddr+4; JAL link value
//  commit      out  1   1-cycle pulse: current instruction retires; regfile WEN qualifier
//  halted      out  1   sticky halt flag
// BEHAVIOUR
//  Reset (nRST=0, asynchronous)
//   - pc=PC_INIT, state=FETCH, dmemREN=dmemWEN=commit=halted=0, imemREN=1 after release.
//   - Reset asserted in any state, including mid-MEM, drops requests immediately.
//  FETCH: imemREN=1, dmemREN=dmemWEN=0.
//   - No ihit: hold pc, commit=0.
//   - ihit & halt: ->HALTED next cycle; pc held; commit=0.
//   - ihit & (cu_dmemREN|cu_dmemWEN): ->MEM; latch dmemREN<=cu_dmemREN and
//     dmemWEN<=cu_dmemWEN; pc held; commit=0.
//   - ihit, otherwise: commit=1 this cycle; pc<=next_pc; stay FETCH.
//   - dhit while in FETCH is ignored.
//  MEM: imemREN=0; dmemREN/dmemWEN hold their latched values.
//   - Wait for dhit.
//   - On dhit: commit=1, pc<=next_pc; clear dmemREN/WEN at the edge; ->FETCH.
//  HALTED: all requests 0, halted=1, pc frozen; exited only by reset.
//  next_pc (combinational, 32-bit, modulo 2^32 so 0xFFFF_FFFC+4 wraps to 0)
//   - PC4EN=1: pc+4.
//   - PC_BR: pc+4 + (sext(imemload[15:0])<<2).
//   - PC_JI: {pc4[31:28], imemload[25:0], 2'b00}.
//   - PC_JR: {rdat1[31:2], 2'b00}; misaligned low bits are cleared.
//   - PC_NP with PC4EN=0 and halt=0: hold pc (stall).
//  Outputs
//   - imemaddr=pc and pc4=pc+4, combinational from the pc register.
//   - commit never asserts in HALTED or while waiting for dhit.
//  Latency
//   - Non-memory instruction: retires in the ihit cycle.
//   - LW/SW: ihit cycle + >=1 MEM cycle; dmem request is visible the cycle after ihit.
// TESTING
//  1 Reset, then ADDIU at 0, ihit held 1 -> commit each cycle; imemaddr 0,4,8.
//  2 LW at 0x10; ihit, dhit 3 cycles later -> dmemREN=1 for 3 cycles, imemREN=0,
//    one commit on dhit, imemaddr=0x14.
//  3 BEQ taken at 0x20, imm=0xFFFE (PC_BR, PC4EN=0) -> next imemaddr=0x1C;
//    J at 0x0 with target 0x40 -> imemaddr=0x100.
//  4 JR with rdat1=0x0000_0203 -> imemaddr=0x200; pc=0xFFFF_FFFC with PC4EN -> wraps to 0.
//  5 HALT with ihit -> halted=1 next cycle; imemREN=dmemREN=dmemWEN=0; pc frozen
//    for 20 cycles, ignoring ihit/dhit.
//  6 nRST pulsed low mid-MEM during SW (dmemWEN=1) -> dmemWEN=0 asynchronously;
//    imemaddr=PC_INIT; FETCH resumes.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues instruction reads and sequences LW/SW data access.
// Instructions retire on ihit, or on dhit for memory instructions; HALT is sticky.
module pc_fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [31:0] imemload,
    input  logic [1:0]  PCsel,
    input  logic        PC4EN,
    input  logic        halt,
    input  logic        cu_dmemREN,
    input  logic        cu_dmemWEN,
    input  logic [31:0] rdat1,
    output logic [31:0] imemaddr,
    output logic        imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] pc4,
    output logic        commit,
    output logic        halted
);

    localparam int unsigned XLEN = 32;
    localparam logic [1:0] PC_NP = 2'd0;
    localparam logic [1:0] PC_JR = 2'd1;
    localparam logic [1:0] PC_JI = 2'd2;
    localparam logic [1:0] PC_BR = 2'd3;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_MEM    = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              dren_q, dren_d;
    logic              dwen_q, dwen_d;
    logic              halted_q, halted_d;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   br_off;
    logic [XLEN-1:0]   next_pc;
    logic              unused_bits;

    assign unused_bits = ^{imemload[31:26], rdat1[1:0]};

    assign pc_plus4 = pc_q + XLEN'(4);
    assign br_off   = {{14{imemload[15]}}, imemload[15:0], 2'b00};

    // Target selection; PC4EN overrides PCsel, PC_NP without PC4EN stalls.
    always_comb begin
        next_pc = pc_q;
        if (PC4EN) begin
            next_pc = pc_plus4;
        end else begin
            case (PCsel)
                PC_BR:   next_pc = pc_plus4 + br_off;
                PC_JI:   next_pc = {pc_plus4[31:28], imemload[25:0], 2'b00};
                PC_JR:   next_pc = {rdat1[31:2], 2'b00};
                PC_NP:   next_pc = pc_q;
                default: next_pc = pc_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_FETCH;
            pc_q     <= PC_INIT;
            dren_q   <= 1'b0;
            dwen_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            dren_q   <= dren_d;
            dwen_q   <= dwen_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        dren_d   = dren_q;
        dwen_d   = dwen_q;
        halted_d = halted_q;
        commit   = 1'b0;
        imemREN  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imemREN = 1'b1;
                dren_d  = 1'b0;
                dwen_d  = 1'b0;
                if (ihit) begin
                    if (halt) begin
                        state_d  = S_HALTED;
                        halted_d = 1'b1;
                    end else if (cu_dmemREN || cu_dmemWEN) begin
                        state_d = S_MEM;
                        dren_d  = cu_dmemREN;
                        dwen_d  = cu_dmemWEN;
                    end else begin
                        commit = 1'b1;
                        pc_d   = next_pc;
                    end
                end
            end
            S_MEM: begin
                if (dhit) begin
                    commit  = 1'b1;
                    pc_d    = next_pc;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                dren_d   = 1'b0;
                dwen_d   = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign imemaddr = pc_q;
    assign pc4      = pc_plus4;
    assign dmemREN  = dren_q;
    assign dmemWEN  = dwen_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pc_fetch_unit;

    localparam logic [1:0] PC_NP = 2'd0;
    localparam logic [1:0] PC_JR = 2'd1;
    localparam logic [1:0] PC_JI = 2'd2;
    localparam logic [1:0] PC_BR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit;
    logic [31:0] imemload;
    logic [1:0]  PCsel;
    logic        PC4EN, halt, cu_dmemREN, cu_dmemWEN;
    logic [31:0] rdat1;
    logic [31:0] imemaddr, pc4;
    logic        imemREN, dmemREN, dmemWEN, commit, halted;

    int total = 0;
    int bad   = 0;

    // Behavioural model: what the stage is doing, not how it is encoded
    logic [31:0] m_pc;
    bit          m_busy_mem;
    bit          m_rd, m_wr;
    bit          m_halted;

    pc_fetch_unit dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .imemload(imemload),
        .PCsel(PCsel), .PC4EN(PC4EN), .halt(halt), .cu_dmemREN(cu_dmemREN),
        .cu_dmemWEN(cu_dmemWEN), .rdat1(rdat1), .imemaddr(imemaddr),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .pc4(pc4),
        .commit(commit), .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [31:0] pc);
        logic [31:0] off;
        off = {{16{imemload[15]}}, imemload[15:0]} * 32'd4;
        if (PC4EN) return pc + 32'd4;
        case (PCsel)
            PC_BR:   return pc + 32'd4 + off;
            PC_JI:   return ((pc + 32'd4) & 32'hF000_0000) | ((imemload & 32'h03FF_FFFF) * 32'd4);
            PC_JR:   return rdat1 & 32'hFFFF_FFFC;
            default: return pc;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_busy_mem = 0; m_rd = 0; m_wr = 0; m_halted = 0;
    endtask

    task automatic compare_model();
        bit exp_commit;
        exp_commit = !m_halted && ((!m_busy_mem && ihit && !halt && !(cu_dmemREN || cu_dmemWEN))
                                   || (m_busy_mem && dhit));
        check("imemaddr", imemaddr, m_pc);
        check("pc4", pc4, m_pc + 32'd4);
        check("imemREN", 32'(imemREN), 32'(!m_halted && !m_busy_mem));
        check("dmemREN", 32'(dmemREN), 32'(m_busy_mem && m_rd));
        check("dmemWEN", 32'(dmemWEN), 32'(m_busy_mem && m_wr));
        check("commit", 32'(commit), 32'(exp_commit));
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    task automatic model_advance();
        logic [31:0] tgt;
        tgt = model_target(m_pc);
        if (m_halted) return;
        if (m_busy_mem) begin
            if (dhit) begin
                m_pc = tgt; m_busy_mem = 0; m_rd = 0; m_wr = 0;
            end
        end else if (ihit) begin
            if (halt) m_halted = 1;
            else if (cu_dmemREN || cu_dmemWEN) begin
                m_busy_mem = 1; m_rd = cu_dmemREN; m_wr = cu_dmemWEN;
            end else m_pc = tgt;
        end
    endtask

    task automatic set_in(input bit ih, input bit dh, input logic [31:0] ld, input logic [1:0] sel,
                          input bit p4, input bit h, input bit ren, input bit wen,
                          input logic [31:0] r1);
        ihit = ih; dhit = dh; imemload = ld; PCsel = sel; PC4EN = p4; halt = h;
        cu_dmemREN = ren; cu_dmemWEN = wen; rdat1 = r1;
    endtask

    // One clock cycle: inputs already driven at posedge+1, compare at posedge+3
    task automatic step();
        #2;
        compare_model();
        @(posedge CLK);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        model_reset();
        check("rst_dmemREN", 32'(dmemREN), 32'd0);
        check("rst_dmemWEN", 32'(dmemWEN), 32'd0);
        check("rst_imemaddr", imemaddr, 32'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic addiu();
        set_in(1, 0, 32'h2408_0001, PC_NP, 1, 0, 0, 0, 32'h0);
    endtask

    initial begin
        int halt_cycles;
        set_in(0, 0, 32'h0, PC_NP, 0, 0, 0, 0, 32'h0);
        nRST = 1'b1;
        #1;
        do_reset();
        check("rst_imemREN", 32'(imemREN), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);

        // 1: ADDIU stream
        for (int i = 0; i < 3; i++) begin
            addiu();
            #1;
            check("t1_addr", imemaddr, 32'(i * 4));
            check("t1_commit", 32'(commit), 32'd1);
            #(-0) ;
            @(negedge CLK);
            @(posedge CLK);
            model_advance();
            #1;
        end
        addiu(); step();
        check("t2_start", imemaddr, 32'h10);

        // 2: LW, dhit on third MEM cycle
        set_in(1, 0, 32'h8C08_0000, PC_NP, 1, 0, 1, 0, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(0, (i == 2), 32'h8C08_0000, PC_NP, 1, 0, 1, 0, 32'h0);
            #1;
            check("t2_dren", 32'(dmemREN), 32'd1);
            check("t2_iren", 32'(imemREN), 32'd0);
            check("t2_commit", 32'(commit), 32'(i == 2));
            #(-0) ;
            #1;
            compare_model();
            @(posedge CLK);
            model_advance();
            #1;
        end
        check("t2_addr", imemaddr, 32'h14);
        check("t2_dren_off", 32'(dmemREN), 32'd0);

        // 3: JR to 0x20, BEQ back to 0x1C, then J from 0 to 0x100
        set_in(1, 0, 32'h0, PC_JR, 0, 0, 0, 0, 32'h20); step();
        set_in(1, 0, 32'h1000_FFFE, PC_BR, 0, 0, 0, 0, 32'h0); step();
        check("t3_beq", imemaddr, 32'h1C);
        set_in(1, 0, 32'h0, PC_JR, 0, 0, 0, 0, 32'h0); step();
        set_in(1, 0, 32'h0800_0040, PC_JI, 0, 0, 0, 0, 32'h0); step();
        check("t3_j", imemaddr, 32'h100);

        // 4: misaligned JR, then wrap at top of address space
        set_in(1, 0, 32'h0, PC_JR, 0, 0, 0, 0, 32'h0000_0203); step();
        check("t4_jr", imemaddr, 32'h200);
        set_in(1, 0, 32'h0, PC_JR, 0, 0, 0, 0, 32'hFFFF_FFFC); step();
        check("t4_pc4_wrap", pc4, 32'h0);
        addiu(); step();
        check("t4_wrap", imemaddr, 32'h0);

        // 5: HALT freezes everything
        set_in(1, 0, 32'h0000_000C, PC_NP, 0, 1, 0, 0, 32'h0); step();
        for (int i = 0; i < 20; i++) begin
            set_in(1, 1, $urandom, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom);
            step();
        end
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_addr", imemaddr, 32'h0);
        check("t5_iren", 32'(imemREN), 32'd0);

        // 6: reset in the middle of a SW
        do_reset();
        addiu(); step();
        set_in(1, 0, 32'hAC08_0000, PC_NP, 1, 0, 0, 1, 32'h0); step();
        set_in(0, 0, 32'hAC08_0000, PC_NP, 1, 0, 0, 1, 32'h0); step();
        check("t6_dwen", 32'(dmemWEN), 32'd1);
        do_reset();
        check("t6_iren", 32'(imemREN), 32'd1);
        addiu(); step();
        check("t6_resume", imemaddr, 32'h4);

        // Randomized traffic
        halt_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (halt_cycles >= 20 || $urandom_range(0, 299) == 0) begin
                do_reset();
                halt_cycles = 0;
            end
            if (!m_busy_mem) begin
                int r;
                r = int'($urandom_range(0, 5));
                set_in(1'($urandom), 1'($urandom), $urandom, 2'($urandom),
                       ($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0),
                       (r == 0), (r == 1), $urandom);
            end else begin
                ihit = 1'($urandom);
                dhit = ($urandom_range(0, 2) == 0);
            end
            step();
            if (m_halted) halt_cycles++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
